if_prefetch_unit: RTL and testbench
===================================

Name: if_prefetch_unit

Overview:
Parametrised successor to the single-entry fetch stage. It decouples instruction-SRAM fetch from ID using a PC-tagged prefetch FIFO of configurable depth. It issues sequential fetches under a credit rule, flushes on branch redirect, and drops any stale in-flight response. It sits between the instruction SRAM (1-cycle read latency) and the ID stage, using the existing br_bus and IF_to_ID_Bus formats.

Parameters:
RESET_PC, 32'h1c000000, address of the first fetch after reset.
FIFO_DEPTH, 4, number of prefetch entries; legal values 2..16.
INST_W, 32, instruction width; IF_to_ID_Bus width is 32+INST_W.

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
ID_Allow_in  in  1  ID accepts the head entry this cycle
br_bus  in  34  {br_taken, br_target[31:0], br_stall}
inst_sram_en  out  1  read request this cycle
inst_sram_we  out  4  tied 4'b0
inst_sram_addr  out  32  fetch address
inst_sram_wdata  out  32  tied 32'b0
inst_sram_rdata  in  INST_W  read data, valid the cycle after en
IF_to_ID_Valid  out  1  head entry valid
IF_to_ID_Bus  out  32+INST_W  {pc, inst} of the head entry

Behaviour:
- Reset (resetn=0 at posedge):
  - fetch_pc=RESET_PC; FIFO count=0; inflight=0.
  - Outputs: inst_sram_en=0, IF_to_ID_Valid=0, IF_to_ID_Bus=0.
  - An in-flight response is discarded.
  - First fetch is issued the first cycle resetn=1.
- State:
  - fetch_pc: next address.
  - inflight flag plus inflight_pc.
  - FIFO of {pc,inst}: head/tail pointers wrapping modulo FIFO_DEPTH, plus count.
- Dequeue: deq = IF_to_ID_Valid && ID_Allow_in; the head pops at the clock edge.
- Issue rule, normal path:
  - issue = !br_stall && (count + inflight - deq) < FIFO_DEPTH.
  - On issue: inst_sram_addr=fetch_pc; at the edge inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap).
  - With no issue, inst_sram_addr still equals fetch_pc.
- Response: if inflight at a cycle start, rdata is captured into the FIFO tail with inflight_pc at that edge. inflight clears unless a new issue occurs.
- Simultaneous enqueue and dequeue: count unchanged. The credit rule guarantees no overflow.
- Redirect (br_taken=1):
  - Highest priority; overrides br_stall and credit.
  - Same cycle: IF_to_ID_Valid=0, inst_sram_en=1, inst_sram_addr=br_target.
  - At the edge: FIFO flushed (count=0, pointers reset), the current in-flight response is dropped (not enqueued), inflight<=1, inflight_pc<=br_target, fetch_pc<=br_target+4.
- br_stall=1 without br_taken: no new issue. The in-flight response still lands; dequeue continues.
- Empty: IF_to_ID_Valid=0 and IF_to_ID_Bus holds its last value; dequeue is ignored.
- Full: count=FIFO_DEPTH; no issue unless deq this cycle.
- Order: entries leave in fetch order; pc values are strictly sequential between redirects.

Optional Feature:
IF_BYPASS_EN defined:
- When the FIFO is empty and a response arrives, the response drives IF_to_ID_Valid=1 and IF_to_ID_Bus={inflight_pc, rdata} combinationally in its arrival cycle.
- If deq, it is not enqueued; otherwise it is enqueued.
- Latency from issue to ID is 1 cycle.
- A redirect in the arrival cycle still forces Valid=0 and drops the response.

IF_BYPASS_EN undefined:
- Responses always enter the FIFO first.
- Issue-to-ID latency is 2 cycles.
- With ID always ready, sustained throughput is still 1 instruction/cycle for FIFO_DEPTH>=2.

Test Plan:
1. Reset release, ID_Allow_in=1 -> addr sequence 1c000000, 1c000004, 1c000008...; bus pc values in same order; first Valid at cycle 2 (cycle 1 with bypass); one instruction per cycle after fill.
2. ID_Allow_in=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 entries held; inst_sram_en=0 once full; release -> pcs 1c000000..1c00000c delivered in order with no gap or duplicate.
3. br_taken with target 1c000100 while FIFO holds 3 entries and 1 in flight -> Valid=0 that cycle; addr=1c000100; next delivered pc is 1c000100; stale data never appears.
4. br_stall=1 for 3 cycles with FIFO empty -> no en; pending response still delivered; fetch resumes at the correct sequential pc.
5. br_taken and br_stall asserted together -> redirect wins; en=1, addr=br_target.
6. resetn low for 1 cycle mid-stream with a full FIFO -> Valid=0 next cycle; fetch restarts at RESET_PC; no old entries delivered.

Source files
------------

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch stage: credit-limited sequential fetch into a PC-tagged FIFO feeding ID.
// Define IF_BYPASS_EN to forward a response straight to ID when the FIFO is empty.
module if_prefetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          INST_W     = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ID_Allow_in,
  input  logic [33:0]         br_bus,
  output logic                inst_sram_en,
  output logic [3:0]          inst_sram_we,
  output logic [31:0]         inst_sram_addr,
  output logic [31:0]         inst_sram_wdata,
  input  logic [INST_W-1:0]   inst_sram_rdata,
  output logic                IF_to_ID_Valid,
  output logic [32+INST_W-1:0] IF_to_ID_Bus
);
  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 32 + INST_W;

  logic        br_taken, br_stall;
  logic [31:0] br_target;
  assign {br_taken, br_target, br_stall} = br_bus;

  logic [31:0]      fetch_pc, inflight_pc;
  logic             inflight;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] last_bus, disp_bus;
  logic             fifo_empty, byp, deq, pop, enq, issue;
  logic [CNT_W:0]   occ;

  assign fifo_empty = (count == '0);
`ifdef IF_BYPASS_EN
  assign byp = fifo_empty && inflight;
`else
  assign byp = 1'b0;
`endif

  assign IF_to_ID_Valid = resetn && !br_taken && (!fifo_empty || byp);
  assign disp_bus       = fifo_empty ? {inflight_pc, inst_sram_rdata} : mem[head];
  // Bus keeps the last presented entry whenever nothing valid is shown
  assign IF_to_ID_Bus   = IF_to_ID_Valid ? disp_bus : last_bus;

  assign deq = IF_to_ID_Valid && ID_Allow_in;
  assign pop = deq && !fifo_empty;
  assign enq = inflight && !br_taken && !(byp && deq);

  // Credit: entries held plus the one in flight, minus the one leaving now
  assign occ   = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(deq);
  assign issue = br_taken || (!br_stall && (occ < (CNT_W+1)'(FIFO_DEPTH)));

  assign inst_sram_en    = resetn && issue;
  assign inst_sram_addr  = br_taken ? br_target : fetch_pc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;

  always_ff @(posedge clk) begin
    if (resetn && enq) mem[tail] <= {inflight_pc, inst_sram_rdata};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      last_bus    <= '0;
    end else begin
      last_bus <= IF_to_ID_Bus;
      if (br_taken) begin
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        inflight    <= 1'b1;
        inflight_pc <= br_target;
        fetch_pc    <= br_target + 32'd4;
      end else begin
        if (enq) tail <= (tail == PTR_W'(FIFO_DEPTH-1)) ? '0 : tail + 1'b1;
        if (pop) head <= (head == PTR_W'(FIFO_DEPTH-1)) ? '0 : head + 1'b1;
        count    <= count + CNT_W'(enq) - CNT_W'(pop);
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + 32'd4;
        end
      end
    end
  end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit against a queue-based reference of the fetch/FIFO rules.
module tb_if_prefetch_unit;
  localparam logic [31:0] RPC = 32'h1c000000;
  localparam int DEPTH = 4;
`ifdef IF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, ID_Allow_in;
  logic [33:0] br_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        IF_to_ID_Valid;
  logic [63:0] IF_to_ID_Bus;

  if_prefetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .INST_W(32)) dut (
    .clk(clk), .resetn(resetn), .ID_Allow_in(ID_Allow_in), .br_bus(br_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata), .IF_to_ID_Valid(IF_to_ID_Valid),
    .IF_to_ID_Bus(IF_to_ID_Bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  // 1-cycle SRAM; garbage when not read so stale captures show up
  always @(posedge clk) inst_sram_rdata <= inst_sram_en ? memf(inst_sram_addr) : $urandom();

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: queue of {pc,inst}, one in-flight slot, next fetch pc, expected delivery pc
  logic [63:0] q[$];
  logic        m_infl = 1'b0;
  logic [31:0] m_ipc = RPC, m_fpc = RPC, exp_pc = RPC;
  logic [63:0] m_last = '0;

  task automatic cyc(input logic a, input logic bt, input logic [31:0] tg,
                     input logic bs, input logic rn);
    logic        v, d, en, consumed;
    logic [63:0] bus;
    int          occ;
    ID_Allow_in = a; br_bus = {bt, tg, bs}; resetn = rn;
    #3;
    v   = rn && !bt && (q.size() != 0 || (BYP && m_infl));
    bus = !v ? m_last : (q.size() != 0 ? q[0] : {m_ipc, memf(m_ipc)});
    d   = v && a;
    occ = q.size() + int'(m_infl) - int'(d);
    en  = rn && (bt || (!bs && occ < DEPTH));
    chk("valid", 64'(IF_to_ID_Valid), 64'(v));
    chk("en",    64'(inst_sram_en),   64'(en));
    chk("addr",  64'(inst_sram_addr), 64'(bt ? tg : m_fpc));
    chk("bus",   IF_to_ID_Bus,        bus);
    chk("tie",   {inst_sram_wdata, 28'b0, inst_sram_we}, 64'b0);
    if (d) begin
      chk("ord_pc",   64'(IF_to_ID_Bus[63:32]), 64'(exp_pc));
      chk("ord_inst", 64'(IF_to_ID_Bus[31:0]),  64'(memf(exp_pc)));
    end
    @(posedge clk);
    if (!rn) begin
      q.delete(); m_infl = 1'b0; m_fpc = RPC; m_last = '0; exp_pc = RPC;
    end else begin
      m_last = bus;
      if (d) exp_pc = exp_pc + 32'd4;
      if (bt) begin
        q.delete(); m_infl = 1'b1; m_ipc = tg; m_fpc = tg + 32'd4; exp_pc = tg;
      end else begin
        consumed = 1'b0;
        if (d) begin
          if (q.size() != 0) void'(q.pop_front());
          else consumed = 1'b1;
        end
        if (m_infl && !consumed) q.push_back({m_ipc, memf(m_ipc)});
        m_infl = en;
        if (en) begin m_ipc = m_fpc; m_fpc = m_fpc + 32'd4; end
      end
    end
    #1;
  endtask

  initial begin
    resetn = 1'b0; ID_Allow_in = 1'b0; br_bus = '0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0);
    // streaming with ID always ready
    repeat (12) cyc(1, 0, 0, 0, 1);
    // ID blocked until full, then drain
    repeat (10) cyc(0, 0, 0, 0, 1);
    repeat (8)  cyc(1, 0, 0, 0, 1);
    // redirect with 3 held + 1 in flight
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 32'h1c000100, 0, 1);
    repeat (8) cyc(1, 0, 0, 0, 1);
    // stall with FIFO empty and a response pending
    cyc(1, 1, 32'h1c000200, 0, 1);
    repeat (3) cyc(1, 0, 0, 1, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // redirect and stall together
    cyc(1, 1, 32'h1c000300, 1, 1);
    repeat (4) cyc(1, 0, 0, 0, 1);
    // reset mid-stream with a full FIFO
    repeat (8) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // address wrap
    cyc(1, 1, 32'hFFFFFFF8, 0, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF4 : ($urandom() & 32'hFFFFFFFC);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tg,
          $urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
